punc_ctrl_mc: RTL and testbench
===============================

PUNC_CTRL_MC -- requirements
Module: punc_ctrl_mc

Interface
REQ-001 Parameter: MEM_WAIT, 0, memory wait states per access (0..7); each access lasts 1+MEM_WAIT cycles.
REQ-002 Parameter: CNT_W, 3, width of the wait-state counter; SHALL satisfy 2^CNT_W > MEM_WAIT.
REQ-003 One clock; reset is synchronous and active-high; ports SHALL be named clk and rst.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 ir  input  16  instruction register contents from the datapath.
REQ-007 n, z, p  input  1 each  condition flags from the datapath.
REQ-008 ir_ld, pc_ld, pc_inc  output  1 each  IR load, PC load, PC increment strobes.
REQ-009 pc_sel  output  2  PC source: 0 = PC+offset9, 1 = PC+offset11, 2 = base register.
REQ-010 mem_addr_sel  output  2  memory address: 0 = PC, 1 = effective address, 2 = memory data register.
REQ-011 mem_we, mdr_ld  output  1 each  memory write enable; memory-data-register load.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_wsel  output  2  write data: 0 = ALU, 1 = memory, 2 = PC, 3 = effective address.
REQ-014 rf_waddr, rf_raddr0, rf_raddr1  output  3 each  register-file addresses.
REQ-015 alu_op  output  2  operation: 0 = ADD, 1 = AND, 2 = NOT, 3 = pass A.
REQ-016 nzp_ld  output  1  flag load; halted  output  1  processor halted.

Function
REQ-017 States SHALL be FETCH, DECODE, EXEC1, EXEC2, HALT; a CNT_W-bit wait counter SHALL extend every memory-access state.
REQ-018 Memory-access states: FETCH; EXEC1 for LD, LDI, LDR, ST, STI, STR; EXEC2 for LDI and STI.
REQ-019 Wait counter:
- clears on entry to a memory-access state;
- increments each cycle while below MEM_WAIT;
- the state advances only in the cycle the counter equals MEM_WAIT.
REQ-020 During an access, address select and read addresses SHALL stay constant.
REQ-021 mem_we, ir_ld, mdr_ld and rf_we SHALL assert only in the final cycle of an access.
REQ-022 FETCH: mem_addr_sel = 0; final cycle asserts ir_ld and pc_inc, then goes to DECODE.
REQ-023 DECODE: one cycle; next state is HALT for TRAP (1111), else EXEC1.
REQ-024 EXEC1 by opcode:
- ADD, AND, NOT: rf_we and nzp_ld.
- BR: pc_ld, pc_sel = 0, only when (ir[11]&n)|(ir[10]&z)|(ir[9]&p); nzp 000 is never taken.
- JMP: pc_ld, pc_sel = 2.
- JSR/JSRR: rf_we to R7 with rf_wsel = 2, plus pc_ld; pc_sel = 1 if ir[11], else 2.
- LEA: rf_we, rf_wsel = 3, nzp_ld.
- LD, LDR: rf_we, rf_wsel = 1, nzp_ld in the final cycle.
- ST, STR: mem_we in the final cycle.
- LDI, STI: mdr_ld in the final cycle, then EXEC2.
REQ-025 EXEC2 uses mem_addr_sel = 2:
- LDI: rf_we and nzp_ld in the final cycle.
- STI: mem_we in the final cycle.
REQ-026 Every EXEC path SHALL return to FETCH.
REQ-027 Unused opcodes (1000, 1101) SHALL act as NOP with a one-cycle EXEC1.
REQ-028 HALT: all strobes are 0 and halted = 1; the state holds until rst.
REQ-029 Instruction latency with W = MEM_WAIT:
- non-memory instructions: 3+W cycles;
- LD/LDR/ST/STR: 3+2W cycles;
- LDI/STI: 4+3W cycles.
REQ-030 All outputs SHALL be combinational decodes of state, counter, ir and flags, with no latches.

Reset
REQ-031 rst SHALL force state FETCH and counter 0 on the next edge, including mid-access and from HALT.
REQ-032 During and immediately after reset, all strobes and halted SHALL be 0, and the select outputs 0.

Configuration
REQ-033 Macro PUNC_CTRL_DEBUG_EN, when defined, SHALL add:
- output dbg_state (3 bits), giving the current state;
- output dbg_icount (16 bits), cleared by rst, incremented at each DECODE and wrapping 0xFFFF to 0.
REQ-034 Without the macro, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 Shared package punc_pkg SHALL hold the opcode constants, the state encodings, and the pc_sel, mem_addr_sel, rf_wsel and alu_op encodings.
REQ-036 Sub-module punc_wait_ctr SHALL hold the parametrised counter, with clear/enable inputs and a done output.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- MEM_WAIT=0, ir=0x1042 (ADD): 3 cycles; rf_we and nzp_ld in cycle 3 with rf_waddr=0.
- MEM_WAIT=2, ir=0xA201 (LDI R1): 10 cycles; ir_ld in cycle 3, mdr_ld in cycle 7, rf_we in cycle 10.
- MEM_WAIT=1, ir=0x3001 (ST): exactly one mem_we pulse, in cycle 5; mem_addr_sel constant during cycles 4-5.
- ir=0x0401 (BRz), z=0 then z=1: pc_ld = 0, then pc_ld = 1 with pc_sel = 0; ir=0x0001 never branches.
- ir=0xF025 (TRAP): halted rises after DECODE and holds 20 cycles; rst returns to FETCH with halted = 0.
- MEM_WAIT=3, rst asserted in wait cycle 2 of FETCH: next cycle is FETCH with counter 0 and no ir_ld.

Source files
------------

// File: rtl/punc_pkg.sv
// Shared encodings for the multi-cycle LC-3 style control unit:
// opcodes, FSM states and the datapath select fields.
package punc_pkg;

   localparam logic [3:0] OP_BR   = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JSR  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_LDR  = 4'h6;
   localparam logic [3:0] OP_STR  = 4'h7;
   localparam logic [3:0] OP_RTI  = 4'h8;
   localparam logic [3:0] OP_NOT  = 4'h9;
   localparam logic [3:0] OP_LDI  = 4'hA;
   localparam logic [3:0] OP_STI  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_RES  = 4'hD;
   localparam logic [3:0] OP_LEA  = 4'hE;
   localparam logic [3:0] OP_TRAP = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC1  = 3'd2,
      S_EXEC2  = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [1:0] PC_OFF9  = 2'd0;
   localparam logic [1:0] PC_OFF11 = 2'd1;
   localparam logic [1:0] PC_BASE  = 2'd2;

   localparam logic [1:0] MA_PC  = 2'd0;
   localparam logic [1:0] MA_EA  = 2'd1;
   localparam logic [1:0] MA_MDR = 2'd2;

   localparam logic [1:0] WS_ALU = 2'd0;
   localparam logic [1:0] WS_MEM = 2'd1;
   localparam logic [1:0] WS_PC  = 2'd2;
   localparam logic [1:0] WS_EA  = 2'd3;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_AND  = 2'd1;
   localparam logic [1:0] ALU_NOT  = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   // Opcodes whose EXEC1 state touches memory.
   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
             (op == OP_ST)  || (op == OP_STR) || (op == OP_STI);
   endfunction

endpackage

// File: rtl/punc_wait_ctr.sv
// Wait-state counter: stretches a memory access to 1+MAX cycles.
// done marks the final cycle of the access.
module punc_wait_ctr #(
   parameter int CNT_W = 3,
   parameter int MAX   = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic done
);

   localparam logic [CNT_W-1:0] LIM = CNT_W'(MAX);

   logic [CNT_W-1:0] cnt;

   assign done = (cnt == LIM);

   // Count up while enabled; clear between accesses.
   always_ff @(posedge clk) begin
      if (rst || clr) cnt <= '0;
      else if (en)    cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/punc_ctrl_mc.sv
// Multi-cycle control FSM with memory wait states.
// Define PUNC_CTRL_DEBUG_EN to add dbg_state / dbg_icount ports.
module punc_ctrl_mc
   import punc_pkg::*;
#(
   parameter int MEM_WAIT = 0,
   parameter int CNT_W    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ir,
   input  logic        n,
   input  logic        z,
   input  logic        p,
   output logic        ir_ld,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic [1:0]  pc_sel,
   output logic [1:0]  mem_addr_sel,
   output logic        mem_we,
   output logic        mdr_ld,
   output logic        rf_we,
   output logic [1:0]  rf_wsel,
   output logic [2:0]  rf_waddr,
   output logic [2:0]  rf_raddr0,
   output logic [2:0]  rf_raddr1,
   output logic [1:0]  alu_op,
   output logic        nzp_ld,
   output logic        halted
`ifdef PUNC_CTRL_DEBUG_EN
   ,
   output logic [2:0]  dbg_state,
   output logic [15:0] dbg_icount
`endif
);

   state_t     state;
   logic [3:0] op;
   logic       mem_state;
   logic       done;
   logic       last;
   logic       taken;
   logic       unused_ir;

   assign op        = ir[15:12];
   assign unused_ir = ^ir[5:3];
   assign taken     = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
   assign mem_state = (state == S_FETCH) || (state == S_EXEC2) ||
                      ((state == S_EXEC1) && is_mem_op(op));
   assign last      = mem_state ? done : 1'b1;

   punc_wait_ctr #(
      .CNT_W (CNT_W),
      .MAX   (MEM_WAIT)
   ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (!mem_state || done),
      .en   (!done),
      .done (done)
   );

   // State sequencing; memory states advance only on done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  if (done) state <= S_DECODE;
            S_DECODE: state <= (op == OP_TRAP) ? S_HALT : S_EXEC1;
            S_EXEC1:
               if (last)
                  state <= (op == OP_LDI || op == OP_STI) ?
                           S_EXEC2 : S_FETCH;
            S_EXEC2:  if (done) state <= S_FETCH;
            S_HALT:   state <= S_HALT;
            default:  state <= S_FETCH;
         endcase
      end
   end

   // Strobe and select decode; everything quiet while in reset.
   always_comb begin
      ir_ld        = 1'b0;
      pc_ld        = 1'b0;
      pc_inc       = 1'b0;
      pc_sel       = PC_OFF9;
      mem_addr_sel = MA_PC;
      mem_we       = 1'b0;
      mdr_ld       = 1'b0;
      rf_we        = 1'b0;
      rf_wsel      = WS_ALU;
      rf_waddr     = 3'd0;
      rf_raddr0    = 3'd0;
      rf_raddr1    = 3'd0;
      alu_op       = ALU_ADD;
      nzp_ld       = 1'b0;
      halted       = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               ir_ld  = done;
               pc_inc = done;
            end
            S_EXEC1: begin
               case (op)
                  OP_ADD, OP_AND, OP_NOT: begin
                     rf_we     = 1'b1;
                     nzp_ld    = 1'b1;
                     rf_waddr  = ir[11:9];
                     rf_raddr0 = ir[8:6];
                     rf_raddr1 = ir[2:0];
                     alu_op    = (op == OP_ADD) ? ALU_ADD :
                                 (op == OP_AND) ? ALU_AND : ALU_NOT;
                  end
                  OP_BR: begin
                     pc_ld  = taken;
                     pc_sel = PC_OFF9;
                  end
                  OP_JMP: begin
                     pc_ld     = 1'b1;
                     pc_sel    = PC_BASE;
                     rf_raddr0 = ir[8:6];
                  end
                  OP_JSR: begin
                     rf_we     = 1'b1;
                     rf_wsel   = WS_PC;
                     rf_waddr  = 3'd7;
                     pc_ld     = 1'b1;
                     pc_sel    = ir[11] ? PC_OFF11 : PC_BASE;
                     rf_raddr0 = ir[8:6];
                  end
                  OP_LEA: begin
                     rf_we    = 1'b1;
                     rf_wsel  = WS_EA;
                     nzp_ld   = 1'b1;
                     rf_waddr = ir[11:9];
                  end
                  OP_LD, OP_LDR: begin
                     mem_addr_sel = MA_EA;
                     rf_we        = done;
                     nzp_ld       = done;
                     rf_wsel      = WS_MEM;
                     rf_waddr     = ir[11:9];
                     rf_raddr0    = (op == OP_LDR) ? ir[8:6] : 3'd0;
                  end
                  OP_ST, OP_STR: begin
                     mem_addr_sel = MA_EA;
                     mem_we       = done;
                     rf_raddr1    = ir[11:9];
                     rf_raddr0    = (op == OP_STR) ? ir[8:6] : 3'd0;
                  end
                  OP_LDI, OP_STI: begin
                     mem_addr_sel = MA_EA;
                     mdr_ld       = done;
                  end
                  default: ;
               endcase
            end
            S_EXEC2: begin
               mem_addr_sel = MA_MDR;
               if (op == OP_LDI) begin
                  rf_we    = done;
                  nzp_ld   = done;
                  rf_wsel  = WS_MEM;
                  rf_waddr = ir[11:9];
               end else begin
                  mem_we    = done;
                  rf_raddr1 = ir[11:9];
               end
            end
            S_HALT:  halted = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef PUNC_CTRL_DEBUG_EN
   assign dbg_state = state;

   // Count decoded instructions; wraps naturally at 16 bits.
   always_ff @(posedge clk) begin
      if (rst)                    dbg_icount <= '0;
      else if (state == S_DECODE) dbg_icount <= dbg_icount + 16'd1;
   end
`endif

endmodule

// File: tb/tb_punc_ctrl_mc.sv
// Directed bench for punc_ctrl_mc: one instance per wait setting
// (MEM_WAIT = 0..3), vector table plus corner-case sequences.
module tb_punc_ctrl_mc;

   logic        clk = 1'b0;
   logic [3:0]  rst_v = 4'hF;
   logic [15:0] ir = 16'h0;
   logic        n = 1'b0, z = 1'b0, p = 1'b0;

   logic [3:0] ir_ld_v, pc_ld_v, pc_inc_v, mem_we_v;
   logic [3:0] mdr_ld_v, rf_we_v, nzp_ld_v, halted_v;
   logic [1:0] pc_sel_v [4];
   logic [1:0] asel_v   [4];
   logic [1:0] wsel_v   [4];
   logic [1:0] alu_v    [4];
   logic [2:0] waddr_v  [4];
   logic [2:0] ra0_v    [4];
   logic [2:0] ra1_v    [4];
`ifdef PUNC_CTRL_DEBUG_EN
   logic [2:0]  dbg_st_v [4];
   logic [15:0] dbg_ic_v [4];
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      punc_ctrl_mc #(.MEM_WAIT(g), .CNT_W(3)) dut (
         .clk          (clk),
         .rst          (rst_v[g]),
         .ir           (ir),
         .n            (n),
         .z            (z),
         .p            (p),
         .ir_ld        (ir_ld_v[g]),
         .pc_ld        (pc_ld_v[g]),
         .pc_inc       (pc_inc_v[g]),
         .pc_sel       (pc_sel_v[g]),
         .mem_addr_sel (asel_v[g]),
         .mem_we       (mem_we_v[g]),
         .mdr_ld       (mdr_ld_v[g]),
         .rf_we        (rf_we_v[g]),
         .rf_wsel      (wsel_v[g]),
         .rf_waddr     (waddr_v[g]),
         .rf_raddr0    (ra0_v[g]),
         .rf_raddr1    (ra1_v[g]),
         .alu_op       (alu_v[g]),
         .nzp_ld       (nzp_ld_v[g]),
         .halted       (halted_v[g])
`ifdef PUNC_CTRL_DEBUG_EN
         ,
         .dbg_state    (dbg_st_v[g]),
         .dbg_icount   (dbg_ic_v[g])
`endif
      );
   end

   typedef struct packed {
      logic       ir_ld, pc_ld, pc_inc, mem_we;
      logic       mdr_ld, rf_we, nzp_ld, halted;
      logic [1:0] pc_sel, asel, wsel, alu;
      logic [2:0] waddr, ra0, ra1;
   } snap_t;

   typedef struct {
      int          k;
      logic [15:0] ir;
      logic [2:0]  nzp;
      int          lat, c_ir, c_mdr, c_we, c_rf, c_pc, c_nz;
      int          wsel, waddr, psel;
   } vec_t;

   snap_t tr [0:63];
   int    n_vec = 0;
   int    n_bad = 0;
   int    lat_m;

   function automatic snap_t grab(input int k);
      snap_t s;
      s.ir_ld  = ir_ld_v[k];
      s.pc_ld  = pc_ld_v[k];
      s.pc_inc = pc_inc_v[k];
      s.mem_we = mem_we_v[k];
      s.mdr_ld = mdr_ld_v[k];
      s.rf_we  = rf_we_v[k];
      s.nzp_ld = nzp_ld_v[k];
      s.halted = halted_v[k];
      s.pc_sel = pc_sel_v[k];
      s.asel   = asel_v[k];
      s.wsel   = wsel_v[k];
      s.alu    = alu_v[k];
      s.waddr  = waddr_v[k];
      s.ra0    = ra0_v[k];
      s.ra1    = ra1_v[k];
      return s;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset(input int k);
      rst_v[k] = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_v[k] = 1'b0;
   endtask

   // 0 = no pulse, c = single pulse in cycle c, 99 = several pulses
   function automatic int pulse(input int id, input int lat);
      int cnt = 0, first = 0;
      logic b;
      for (int c = 1; c <= lat; c++) begin
         case (id)
            0: b = tr[c].ir_ld;
            1: b = tr[c].mdr_ld;
            2: b = tr[c].mem_we;
            3: b = tr[c].rf_we;
            4: b = tr[c].pc_ld;
            5: b = tr[c].nzp_ld;
            default: b = tr[c].pc_inc;
         endcase
         if (b) begin
            cnt++;
            if (first == 0) first = c;
         end
      end
      return (cnt == 0) ? 0 : (cnt == 1) ? first : 99;
   endfunction

   // Reset instance k, run one instruction, record trace until next fetch.
   task automatic run(input int k, input logic [15:0] i,
                      input logic [2:0] f, output int lat);
      int seen = 0;
      ir = i;
      {n, z, p} = f;
      do_reset(k);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         tr[c] = grab(k);
         if (tr[c].ir_ld) seen++;
         @(posedge clk);
         #1;
         if (seen == 2) begin
            lat = c - (1 + k);
            break;
         end
      end
   endtask

   vec_t vt [17];

   initial begin
      snap_t s, e;
      int    bad, first;

      //        k  ir        nzp     lat ir mdr we rf pc nz wsel wa ps
      vt[0]  = '{0, 16'h1042, 3'b000, 3, 1, 0, 0, 3, 0, 3, 0, 0, 0};
      vt[1]  = '{2, 16'hA201, 3'b000, 10, 3, 7, 0, 10, 0, 10, 1, 1, 0};
      vt[2]  = '{1, 16'h3001, 3'b000, 5, 2, 0, 5, 0, 0, 0, 0, 0, 0};
      vt[3]  = '{0, 16'h0401, 3'b101, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[4]  = '{0, 16'h0401, 3'b010, 3, 1, 0, 0, 0, 3, 0, 0, 0, 0};
      vt[5]  = '{0, 16'h0001, 3'b111, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{1, 16'h2A05, 3'b000, 5, 2, 0, 0, 5, 0, 5, 1, 5, 0};
      vt[7]  = '{1, 16'hB601, 3'b000, 7, 2, 5, 7, 0, 0, 0, 0, 0, 0};
      vt[8]  = '{0, 16'h4801, 3'b000, 3, 1, 0, 0, 3, 3, 0, 2, 7, 1};
      vt[9]  = '{0, 16'h4080, 3'b000, 3, 1, 0, 0, 3, 3, 0, 2, 7, 2};
      vt[10] = '{0, 16'hC1C0, 3'b000, 3, 1, 0, 0, 0, 3, 0, 0, 0, 2};
      vt[11] = '{0, 16'hE9FF, 3'b000, 3, 1, 0, 0, 3, 0, 3, 3, 4, 0};
      vt[12] = '{3, 16'h6443, 3'b000, 9, 4, 0, 0, 9, 0, 9, 1, 2, 0};
      vt[13] = '{1, 16'hD000, 3'b000, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[14] = '{2, 16'h7000, 3'b000, 7, 3, 0, 7, 0, 0, 0, 0, 0, 0};
      vt[15] = '{0, 16'h9FFF, 3'b000, 3, 1, 0, 0, 3, 0, 3, 0, 7, 0};
      vt[16] = '{3, 16'h1642, 3'b000, 6, 4, 0, 0, 6, 0, 6, 0, 3, 0};

      // outputs held quiet while reset is asserted
      ir = 16'hF025;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      for (int k = 0; k < 4; k++)
         chk($sformatf("reset_outs_w%0d", k), int'(grab(k)), 0);

      foreach (vt[i]) begin
         run(vt[i].k, vt[i].ir, vt[i].nzp, lat_m);
         chk($sformatf("v%0d_latency", i), lat_m, vt[i].lat);
         if (lat_m < 1) lat_m = 39;
         chk($sformatf("v%0d_ir_ld", i), pulse(0, lat_m), vt[i].c_ir);
         chk($sformatf("v%0d_pc_inc", i), pulse(6, lat_m), vt[i].c_ir);
         chk($sformatf("v%0d_mdr_ld", i), pulse(1, lat_m), vt[i].c_mdr);
         chk($sformatf("v%0d_mem_we", i), pulse(2, lat_m), vt[i].c_we);
         chk($sformatf("v%0d_rf_we", i), pulse(3, lat_m), vt[i].c_rf);
         chk($sformatf("v%0d_pc_ld", i), pulse(4, lat_m), vt[i].c_pc);
         chk($sformatf("v%0d_nzp_ld", i), pulse(5, lat_m), vt[i].c_nz);
         if (vt[i].c_rf > 0 && vt[i].c_rf < 64) begin
            s = tr[vt[i].c_rf];
            chk($sformatf("v%0d_rf_wsel", i), int'(s.wsel), vt[i].wsel);
            chk($sformatf("v%0d_rf_waddr", i), int'(s.waddr), vt[i].waddr);
         end
         if (vt[i].c_pc > 0 && vt[i].c_pc < 64)
            chk($sformatf("v%0d_pc_sel", i),
                int'(tr[vt[i].c_pc].pc_sel), vt[i].psel);
      end

      // ST, W=1: address select and data register stable across EXEC1
      run(1, 16'h3001, 3'b000, lat_m);
      chk("st_asel_c4", int'(tr[4].asel), 1);
      chk("st_asel_c5", int'(tr[5].asel), 1);
      chk("st_ra1_c4", int'(tr[4].ra1), 0);
      chk("st_ra1_c5", int'(tr[5].ra1), 0);

      // LDI, W=2: indirect phase addresses through MDR for all 3 cycles
      run(2, 16'hA201, 3'b000, lat_m);
      bad = 0;
      for (int c = 8; c <= 10; c++)
         if (tr[c].asel != 2'd2) bad++;
      chk("ldi_exec2_asel_bad_cycles", bad, 0);
      chk("ldi_exec1_asel", int'(tr[5].asel), 1);

      // TRAP, W=0: halt after DECODE, hold 20 cycles, reset recovers
      ir = 16'hF025;
      {n, z, p} = 3'b000;
      do_reset(0);
      for (int c = 1; c <= 2; c++) begin
         @(negedge clk);
         tr[c] = grab(0);
         @(posedge clk);
         #1;
      end
      chk("trap_halted_c2", int'(tr[2].halted), 0);
      e = '0;
      e.halted = 1'b1;
      bad = 0;
      for (int c = 3; c <= 22; c++) begin
         @(negedge clk);
         if (grab(0) != e) bad++;
         @(posedge clk);
         #1;
      end
      chk("trap_halt_hold_bad_cycles", bad, 0);
      rst_v[0] = 1'b1;
      @(negedge clk);
      chk("trap_in_reset", int'(grab(0)), 0);
      @(posedge clk);
      #1 rst_v[0] = 1'b0;
      @(negedge clk);
      s = grab(0);
      chk("trap_after_rst_halted", int'(s.halted), 0);
      chk("trap_after_rst_ir_ld", int'(s.ir_ld), 1);
      @(posedge clk);
      #1;

      // W=3: reset in wait cycle 2 of FETCH restarts the access
      ir = 16'h1042;
      do_reset(3);
      @(negedge clk);
      @(posedge clk);
      #1 rst_v[3] = 1'b1;
      @(negedge clk);
      chk("midfetch_in_reset", int'(grab(3)), 0);
      @(posedge clk);
      #1 rst_v[3] = 1'b0;
      first = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (ir_ld_v[3] && first == 0) first = c;
         @(posedge clk);
         #1;
      end
      chk("midfetch_first_ir_ld", first, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
